// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// fetch_queue_if : fetch-side and decode-side signals of the instruction queue
// Rev 1.0
// ============================================================================
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic [31:0]      in_inst;
    logic [63:0]      in_pc;
    logic             fetch_awaiting;
    logic             flush;
    logic             out_valid;
    logic [31:0]      out_inst;
    logic [63:0]      out_pc;
    logic             out_ready;
    logic             fetch_stall;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output in_valid, in_inst, in_pc, fetch_awaiting, flush, out_ready,
        input  out_valid, out_inst, out_pc, fetch_stall, count, overflow
    );

    modport slave (
        input  in_valid, in_inst, in_pc, fetch_awaiting, flush, out_ready,
        output out_valid, out_inst, out_pc, fetch_stall, count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : first-word-fall-through instruction buffer from IF to ID
// Rev 1.0
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH  = 4,
    parameter logic [63:0] PCINIT = 64'h0000_0000_8000_0000
) (
    input  wire logic     clk,
    input  wire logic     rst,
    fetch_queue_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_STALL = CNT_W'(DEPTH - 1);

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               drop_pending_q, drop_pending_d;
    logic               overflow_q, overflow_d;
    entry_t             last_q, last_d;

    logic               w_not_empty;
    logic               w_full;
    logic               w_accept;
    logic               w_pop;
    logic               w_push;
    entry_t             w_head;

    assign w_not_empty = (count_q != '0);
    assign w_full      = (count_q == C_FULL);
    assign w_head      = mem_q[head_q];
    assign w_pop       = w_not_empty & bus.out_ready & ~bus.flush;
    // A word is a candidate for storage only if it is neither flushed nor stale.
    assign w_accept    = bus.in_valid & ~bus.flush & ~drop_pending_q;
    assign w_push      = w_accept & (~w_full | w_pop);

    always_comb begin
        mem_d = mem_q;
        if (w_push) begin
            mem_d[tail_q] = entry_t'{inst: bus.in_inst, pc: bus.in_pc};
        end
    end

    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        drop_pending_d = drop_pending_q;
        overflow_d     = overflow_q | (w_accept & w_full & ~w_pop);
        last_d         = w_pop ? w_head : last_q;

        if (bus.flush) begin
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
            // The in-flight response is stale unless it is arriving right now.
            drop_pending_d = bus.fetch_awaiting & ~bus.in_valid;
        end else begin
            if (drop_pending_q && bus.in_valid) begin
                drop_pending_d = 1'b0;
            end
            if (w_pop) begin
                head_d = head_q + PTR_W'(1);
            end
            if (w_push) begin
                tail_d = tail_q + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            drop_pending_q <= 1'b0;
            overflow_q     <= 1'b0;
            last_q         <= entry_t'{inst: 32'h0, pc: PCINIT};
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            drop_pending_q <= drop_pending_d;
            overflow_q     <= overflow_d;
            last_q         <= last_d;
        end
    end

    // When empty, show the most recently consumed entry rather than a stale slot.
    assign bus.out_valid   = w_not_empty;
    assign bus.out_inst    = w_not_empty ? w_head.inst : last_q.inst;
    assign bus.out_pc      = w_not_empty ? w_head.pc   : last_q.pc;
    assign bus.fetch_stall = (count_q >= C_STALL);
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : scoreboard bench for the fetch-to-decode instruction queue
// Rev 1.0
// ============================================================================
module tb_fetch_queue;
    localparam int          DEPTH  = 4;
    localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_queue_if #(.DEPTH(DEPTH)) bus();

    fetch_queue #(.DEPTH(DEPTH), .PCINIT(PCINIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t sb[$];
    bit   m_drop  = 1'b0;
    bit   m_ovf   = 1'b0;
    bit   m_fresh = 1'b0;
    bit   m_live  = 1'b0;
    int   n_vec   = 0;
    int   n_err   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour, advanced with the same inputs the DUT samples.
    task automatic model_step();
        bit popd;
        bit arr;
        if (rst) begin
            sb.delete();
            m_drop  = 1'b0;
            m_ovf   = 1'b0;
            m_fresh = 1'b1;
            m_live  = 1'b1;
        end else if (m_live) begin
            if (bus.flush) begin
                sb.delete();
                m_drop = bus.fetch_awaiting && !bus.in_valid;
            end else begin
                popd = (sb.size() != 0) && bus.out_ready;
                arr  = bus.in_valid && !m_drop;
                if (bus.in_valid && m_drop) m_drop = 1'b0;
                if (popd) begin
                    void'(sb.pop_front());
                    m_fresh = 1'b0;
                end
                if (arr) begin
                    if (sb.size() < DEPTH) sb.push_back(ent_t'{inst: bus.in_inst, pc: bus.in_pc});
                    else m_ovf = 1'b1;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check_val("out_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
            check_val("count", 64'(bus.count), 64'(sb.size()));
            check_val("fetch_stall", 64'(bus.fetch_stall), 64'(sb.size() >= DEPTH - 1));
            check_val("overflow", 64'(bus.overflow), 64'(m_ovf));
            if (sb.size() != 0) begin
                check_val("head_pc", bus.out_pc, sb[0].pc);
                check_val("head_inst", 64'(bus.out_inst), 64'(sb[0].inst));
            end else if (m_fresh) begin
                check_val("idle_pc", bus.out_pc, PCINIT);
                check_val("idle_inst", 64'(bus.out_inst), 64'h0);
            end
        end
    end

    task automatic cyc(input bit v, input logic [63:0] pc, input logic [31:0] inst,
                       input bit rdy, input bit fl, input bit aw, input bit r);
        bus.in_valid       = v;
        bus.in_pc          = pc;
        bus.in_inst        = inst;
        bus.out_ready      = rdy;
        bus.flush          = fl;
        bus.fetch_awaiting = aw;
        rst                = r;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        rst          = 1'b0;
    endtask

    function automatic logic [31:0] ins(input logic [63:0] pc);
        return pc[31:0] ^ 32'h0000_0013;
    endfunction

    task automatic push(input logic [63:0] pc);
        cyc(1'b1, pc, ins(pc), 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bus.in_valid       = 1'b0;
        bus.in_pc          = 64'h0;
        bus.in_inst        = 32'h0;
        bus.out_ready      = 1'b0;
        bus.flush          = 1'b0;
        bus.fetch_awaiting = 1'b0;
        rst                = 1'b1;
        cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_val("rst_pc", bus.out_pc, PCINIT);
        check_val("rst_count", 64'(bus.count), 64'h0);

        // Basic fill and drain
        cyc(1'b1, 64'h8000_0000, 32'h0000_0093, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 64'h8000_0004, 32'h0010_0113, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 64'h8000_0008, 32'h0020_0193, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("fill_count", 64'(bus.count), 64'd3);
        check_val("fill_stall", 64'(bus.fetch_stall), 64'd1);
        check_val("fill_head", bus.out_pc, 64'h8000_0000);
        drain(4);
        @(negedge clk);
        check_val("drained_valid", 64'(bus.out_valid), 64'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) push(64'(i * 4));
        cyc(1'b1, 64'h10, ins(64'h10), 1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_val("pp_count", 64'(bus.count), 64'd4);
        check_val("pp_head", bus.out_pc, 64'h4);
        check_val("pp_ovf", 64'(bus.overflow), 64'd0);
        drain(5);

        // Overflow
        for (int i = 0; i < 4; i++) push(64'h50 + 64'(i * 4));
        push(64'h20);
        @(negedge clk);
        check_val("ovf_set", 64'(bus.overflow), 64'd1);
        drain(5);
        check_val("ovf_sticky", 64'(bus.overflow), 64'd1);

        // Flush with an in-flight fetch
        push(64'h30);
        push(64'h34);
        cyc(1'b0, 64'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_val("fl_count", 64'(bus.count), 64'd0);
        check_val("fl_valid", 64'(bus.out_valid), 64'd0);
        push(64'h40);
        push(64'h100);
        @(negedge clk);
        check_val("fl_next_pc", bus.out_pc, 64'h100);
        check_val("fl_next_cnt", 64'(bus.count), 64'd1);
        drain(2);

        // Flush coincident with arrival
        cyc(1'b1, 64'h44, ins(64'h44), 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        check_val("fa_count", 64'(bus.count), 64'd0);
        push(64'h200);
        @(negedge clk);
        check_val("fa_next_pc", bus.out_pc, 64'h200);
        drain(2);

        // Wrap-around with toggling ready, then reset while holding entries
        cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            cyc((i % 2) == 0, 64'((i / 2) * 4), ins(64'((i / 2) * 4)),
                (i % 2) == 1, 1'b0, 1'b1, 1'b0);
        end
        drain(3);
        push(64'h60);
        push(64'h64);
        push(64'h68);
        cyc(1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_val("mr_count", 64'(bus.count), 64'd0);
        check_val("mr_valid", 64'(bus.out_valid), 64'd0);
        check_val("mr_ovf", 64'(bus.overflow), 64'd0);
        check_val("mr_pc", bus.out_pc, PCINIT);
        drain(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
